// File: rtl/lstm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lstm_ctrl_pkg
// Description : Shared op_mode encoding and default parameter constants for
//               the LSTM sequence controller and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package lstm_ctrl_pkg;

  // Sequencer state; the value is driven directly onto op_mode.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    INIT_W = 3'b001,
    W_IN   = 3'b011,
    CALC   = 3'b100,
    R_OUT  = 3'b101,
    ERR    = 3'b111
  } op_mode_e;

  localparam int unsigned DEF_N_WBANKS     = 2;
  localparam int unsigned DEF_BANK_BITS    = 3;
  localparam int unsigned DEF_SEQ_LEN_BITS = 8;
  localparam int unsigned DEF_TIMEOUT_BITS = 16;

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Per-state stall counter. Flags expiry in the cycle in which
//               the count would reach all-ones, so a stuck state is left
//               after 2**TIMEOUT_BITS-1 cycles of residence.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_BITS-1:0] C_ALL_ONES = '1;
  localparam logic [TIMEOUT_BITS-1:0] C_PRE_LAST = C_ALL_ONES - TIMEOUT_BITS'(1);

  logic [TIMEOUT_BITS-1:0] cnt_d;
  logic [TIMEOUT_BITS-1:0] cnt_q;

  // Expiry is independent of clear so the FSM's next-state logic, which
  // drives clear, never loops back through this flag.
  assign expired = enable && (cnt_q == C_PRE_LAST);

  // Next count: clear wins, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + TIMEOUT_BITS'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lstm_seq_ctrl
// Description : Sequencer for weight load / input load / calculate / read-out
//               over a programmable number of timesteps, with weight reuse,
//               per-state watchdog, abort and error state. Moore outputs only.
// Revision    : 1.0 - initial release
// ============================================================================
module lstm_seq_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int unsigned N_WBANKS     = DEF_N_WBANKS,
  parameter int unsigned BANK_BITS    = DEF_BANK_BITS,
  parameter int unsigned SEQ_LEN_BITS = DEF_SEQ_LEN_BITS,
  parameter int unsigned TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    keep_weights,
  input  logic [SEQ_LEN_BITS-1:0] seq_len,
  input  logic                    abort,
  input  logic                    err_clear,
  input  logic [N_WBANKS-1:0]     w_init_done,
  input  logic                    w_in_done,
  input  logic                    calc_done,
  input  logic                    r_out_done,
  output logic [2:0]              op_mode,
  output logic [N_WBANKS-1:0]     w_init_start,
  output logic [BANK_BITS-1:0]    bank_idx,
  output logic [SEQ_LEN_BITS-1:0] step_cnt,
  output logic                    weights_valid,
  output logic                    busy,
  output logic                    seq_done,
  output logic                    aborted,
  output logic [2:0]              err_code
);

  localparam logic [BANK_BITS-1:0]    C_LAST_BANK = BANK_BITS'(N_WBANKS - 1);
  localparam logic [SEQ_LEN_BITS-1:0] C_STEP_MAX  = '1;

  op_mode_e                state_d,    state_q;
  logic [BANK_BITS-1:0]    bank_d,     bank_q;
  logic [SEQ_LEN_BITS-1:0] step_d,     step_q;
  logic [SEQ_LEN_BITS-1:0] seq_len_d,  seq_len_q;
  logic                    wvalid_d,   wvalid_q;
  logic                    seq_done_d, seq_done_q;
  logic                    aborted_d,  aborted_q;
  logic [2:0]              err_code_d, err_code_q;

  logic [N_WBANKS-1:0]     bank_onehot;
  logic                    bank_hit;
  logic [SEQ_LEN_BITS-1:0] step_inc;
  logic                    busy_w;
  logic                    wd_clear;
  logic                    wd_expired;

  // Decode helpers from registered state only.
  always_comb begin
    bank_onehot = N_WBANKS'(1) << bank_q;
    bank_hit    = |(w_init_done & bank_onehot);
    step_inc    = (step_q == C_STEP_MAX) ? step_q : step_q + SEQ_LEN_BITS'(1);
    busy_w      = (state_q != IDLE) && (state_q != ERR);
  end

  // Watchdog restarts on any state change and is held clear while idle.
  assign wd_clear = (state_d != state_q) || !busy_w;

  seq_watchdog #(
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_watchdog (
    .clk     (sys_clk),
    .rst     (reset),
    .clear   (wd_clear),
    .enable  (busy_w),
    .expired (wd_expired)
  );

  // Next-state logic: abort beats a done input, which beats watchdog expiry.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    step_d     = step_q;
    seq_len_d  = seq_len_q;
    wvalid_d   = wvalid_q;
    seq_done_d = 1'b0;
    aborted_d  = 1'b0;
    err_code_d = err_code_q;

    if (busy_w && abort) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
      bank_d    = '0;
      if (state_q == INIT_W) begin
        wvalid_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            seq_len_d = seq_len;
            step_d    = '0;
            if (seq_len == '0) begin
              seq_done_d = 1'b1;
            end else if (keep_weights && wvalid_q) begin
              state_d = W_IN;
            end else begin
              state_d  = INIT_W;
              bank_d   = '0;
              wvalid_d = 1'b0;
            end
          end
        end
        INIT_W: begin
          if (bank_hit) begin
            if (bank_q == C_LAST_BANK) begin
              wvalid_d = 1'b1;
              bank_d   = '0;
              state_d  = W_IN;
            end else begin
              bank_d = bank_q + BANK_BITS'(1);
            end
          end
        end
        W_IN: begin
          if (w_in_done) begin
            state_d = CALC;
          end
        end
        CALC: begin
          if (calc_done) begin
            state_d = R_OUT;
          end
        end
        R_OUT: begin
          if (r_out_done) begin
            step_d = step_inc;
            if (step_inc == seq_len_q) begin
              state_d    = IDLE;
              seq_done_d = 1'b1;
            end else begin
              state_d = W_IN;
            end
          end
        end
        ERR: begin
          if (err_clear) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // A stalled state only errors if it did not advance this cycle.
      if (wd_expired && (state_d == state_q)) begin
        state_d    = ERR;
        err_code_d = state_q;
        wvalid_d   = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      step_q     <= '0;
      seq_len_q  <= '0;
      wvalid_q   <= 1'b0;
      seq_done_q <= 1'b0;
      aborted_q  <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      step_q     <= step_d;
      seq_len_q  <= seq_len_d;
      wvalid_q   <= wvalid_d;
      seq_done_q <= seq_done_d;
      aborted_q  <= aborted_d;
      err_code_q <= err_code_d;
    end
  end

  assign op_mode       = state_q;
  assign w_init_start  = (state_q == INIT_W) ? bank_onehot : '0;
  assign bank_idx      = bank_q;
  assign step_cnt      = step_q;
  assign weights_valid = wvalid_q;
  assign busy          = busy_w;
  assign seq_done      = seq_done_q;
  assign aborted       = aborted_q;
  assign err_code      = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lstm_seq_ctrl
// Description : Directed self-checking bench for lstm_seq_ctrl (two banks,
//               4-bit watchdog): vector table plus hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_seq_ctrl;
  import lstm_ctrl_pkg::*;

  logic       sys_clk = 1'b0;
  logic       reset, start, keep_weights, abort, err_clear;
  logic [7:0] seq_len;
  logic [1:0] w_init_done;
  logic       w_in_done, calc_done, r_out_done;
  logic [2:0] op_mode;
  logic [1:0] w_init_start;
  logic [2:0] bank_idx;
  logic [7:0] step_cnt;
  logic       weights_valid, busy, seq_done, aborted;
  logic [2:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  lstm_seq_ctrl #(
    .N_WBANKS     (2),
    .BANK_BITS    (3),
    .SEQ_LEN_BITS (8),
    .TIMEOUT_BITS (4)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .start         (start),
    .keep_weights  (keep_weights),
    .seq_len       (seq_len),
    .abort         (abort),
    .err_clear     (err_clear),
    .w_init_done   (w_init_done),
    .w_in_done     (w_in_done),
    .calc_done     (calc_done),
    .r_out_done    (r_out_done),
    .op_mode       (op_mode),
    .w_init_start  (w_init_start),
    .bank_idx      (bank_idx),
    .step_cnt      (step_cnt),
    .weights_valid (weights_valid),
    .busy          (busy),
    .seq_done      (seq_done),
    .aborted       (aborted),
    .err_code      (err_code)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       start;
    logic       keep;
    logic [7:0] len;
    logic       abort;
    logic       eclr;
    logic [1:0] wid;
    logic       win;
    logic       cdone;
    logic       rdone;
    logic [2:0] e_mode;
    logic [1:0] e_ws;
    logic [2:0] e_bank;
    logic [7:0] e_step;
    logic       e_wv;
    logic       e_busy;
    logic       e_sd;
    logic       e_ab;
  } vec_t;

  vec_t tbl [20];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    start = 0; keep_weights = 0; seq_len = 0; abort = 0; err_clear = 0;
    w_init_done = 0; w_in_done = 0; calc_done = 0; r_out_done = 0;
  endtask

  // Stay in state m for five cycles, pulsing the matching done on the fifth.
  task automatic serve(input op_mode_e m, input int bank);
    for (int i = 0; i < 5; i++) begin
      check("serve_mode", 32'(op_mode), 32'(m));
      check("serve_seq_done", 32'(seq_done), 0);
      if (m == INIT_W) begin
        check("serve_wstart", 32'(w_init_start), 32'(1) << bank);
        check("serve_bank", 32'(bank_idx), bank);
      end
      if (i == 4) begin
        case (m)
          INIT_W:  w_init_done = 2'(1 << bank);
          W_IN:    w_in_done   = 1'b1;
          CALC:    calc_done   = 1'b1;
          default: r_out_done  = 1'b1;
        endcase
      end
      tick();
      w_init_done = 0; w_in_done = 0; calc_done = 0; r_out_done = 0;
    end
  endtask

  // From IDLE, load both banks immediately and land in CALC.
  task automatic go_to_calc(input logic [7:0] len);
    start = 1; seq_len = len; tick(); start = 0;
    w_init_done = 2'b01; tick();
    w_init_done = 2'b10; tick(); w_init_done = 0;
    w_in_done = 1; tick(); w_in_done = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    check("rst_mode",   32'(op_mode), 0);
    check("rst_wstart", 32'(w_init_start), 0);
    check("rst_bank",   32'(bank_idx), 0);
    check("rst_step",   32'(step_cnt), 0);
    check("rst_wv",     32'(weights_valid), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_sd",     32'(seq_done), 0);
    check("rst_ab",     32'(aborted), 0);
    check("rst_err",    32'(err_code), 0);
    reset = 0;
    tick();

    // Test 1: full three-step sequence with five-cycle responses.
    start = 1; seq_len = 3; tick(); start = 0;
    serve(INIT_W, 0);
    serve(INIT_W, 1);
    check("t1_wv_after_init", 32'(weights_valid), 1);
    for (int s = 0; s < 3; s++) begin
      serve(W_IN, 0);
      serve(CALC, 0);
      serve(R_OUT, 0);
      if (s < 2) check("t1_step", 32'(step_cnt), s + 1);
    end
    check("t1_end_mode", 32'(op_mode), 0);
    check("t1_end_step", 32'(step_cnt), 3);
    check("t1_end_sd",   32'(seq_done), 1);
    check("t1_end_wv",   32'(weights_valid), 1);
    check("t1_end_busy", 32'(busy), 0);
    tick();
    check("t1_sd_pulse", 32'(seq_done), 0);

    // Test 2: weight reuse skips INIT_W.
    start = 1; keep_weights = 1; seq_len = 1; tick(); start = 0; keep_weights = 0;
    check("t2_skip_mode", 32'(op_mode), 32'(W_IN));
    check("t2_step0",     32'(step_cnt), 0);
    serve(W_IN, 0);
    serve(CALC, 0);
    serve(R_OUT, 0);
    check("t2_end_mode", 32'(op_mode), 0);
    check("t2_end_sd",   32'(seq_done), 1);
    check("t2_end_step", 32'(step_cnt), 1);
    tick();

    // Tests 3, 5 and 6a: single-cycle vectors.
    //          st kp len ab ec wid win cd rd | mode     ws    bk  stp wv bs sd ab
    tbl[0]  = '{1, 0, 2, 0, 0, 2'b00, 0, 0, 0, 3'b001, 2'b01, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 3'b001, 2'b01, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 3'b001, 2'b10, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 3'b001, 2'b10, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 3'b011, 2'b00, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 3'b100, 2'b00, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 3'b101, 2'b00, 0, 0, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b011, 2'b00, 0, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 1, 1, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 1, 1, 0, 0, 0};
    tbl[10] = '{1, 1, 2, 0, 0, 2'b00, 0, 0, 0, 3'b011, 2'b00, 0, 0, 1, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0};
    tbl[13] = '{1, 0, 2, 0, 0, 2'b00, 0, 0, 0, 3'b001, 2'b01, 0, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1};
    tbl[15] = '{1, 1, 2, 0, 0, 2'b00, 0, 0, 0, 3'b001, 2'b01, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1};
    tbl[17] = '{1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0};

    for (int v = 0; v < 20; v++) begin
      start = tbl[v].start; keep_weights = tbl[v].keep; seq_len = tbl[v].len;
      abort = tbl[v].abort; err_clear = tbl[v].eclr; w_init_done = tbl[v].wid;
      w_in_done = tbl[v].win; calc_done = tbl[v].cdone; r_out_done = tbl[v].rdone;
      tick();
      clear_inputs();
      check($sformatf("vec%0d_mode", v),  32'(op_mode),       32'(tbl[v].e_mode));
      check($sformatf("vec%0d_ws", v),    32'(w_init_start),  32'(tbl[v].e_ws));
      check($sformatf("vec%0d_bank", v),  32'(bank_idx),      32'(tbl[v].e_bank));
      check($sformatf("vec%0d_step", v),  32'(step_cnt),      32'(tbl[v].e_step));
      check($sformatf("vec%0d_wv", v),    32'(weights_valid), 32'(tbl[v].e_wv));
      check($sformatf("vec%0d_busy", v),  32'(busy),          32'(tbl[v].e_busy));
      check($sformatf("vec%0d_sd", v),    32'(seq_done),      32'(tbl[v].e_sd));
      check($sformatf("vec%0d_ab", v),    32'(aborted),       32'(tbl[v].e_ab));
    end

    // Test 4: watchdog expiry in CALC after 15 cycles of residence.
    go_to_calc(8'd1);
    check("t4_calc_entry", 32'(op_mode), 32'(CALC));
    for (int k = 1; k < 15; k++) begin
      tick();
      check("t4_calc_hold", 32'(op_mode), 32'(CALC));
    end
    tick();
    check("t4_err_mode", 32'(op_mode), 32'(ERR));
    check("t4_err_code", 32'(err_code), 32'b100);
    check("t4_err_wv",   32'(weights_valid), 0);
    check("t4_err_busy", 32'(busy), 0);
    start = 1; seq_len = 1; tick(); start = 0;
    check("t4_start_ignored", 32'(op_mode), 32'(ERR));
    err_clear = 1; tick(); err_clear = 0;
    check("t4_clear_idle", 32'(op_mode), 32'(IDLE));

    // Repeat with calc_done landing on the expiry cycle.
    go_to_calc(8'd1);
    for (int k = 1; k < 15; k++) tick();
    check("t4b_still_calc", 32'(op_mode), 32'(CALC));
    calc_done = 1; tick(); calc_done = 0;
    check("t4b_rout", 32'(op_mode), 32'(R_OUT));
    r_out_done = 1; tick(); r_out_done = 0;
    check("t4b_idle", 32'(op_mode), 32'(IDLE));
    check("t4b_sd",   32'(seq_done), 1);
    check("t4b_wv",   32'(weights_valid), 1);

    // Test 6b: synchronous reset mid-CALC.
    start = 1; keep_weights = 1; seq_len = 2; tick(); clear_inputs();
    w_in_done = 1; tick(); w_in_done = 0;
    check("t6_in_calc", 32'(op_mode), 32'(CALC));
    reset = 1; tick();
    check("t6_rst_mode", 32'(op_mode), 0);
    check("t6_rst_ws",   32'(w_init_start), 0);
    check("t6_rst_bank", 32'(bank_idx), 0);
    check("t6_rst_step", 32'(step_cnt), 0);
    check("t6_rst_wv",   32'(weights_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_err",  32'(err_code), 0);
    reset = 0; tick();
    check("t6_post_rst", 32'(op_mode), 0);

    // Saturation boundary: seq_len = 255 completes without wrap.
    start = 1; seq_len = 8'd255; tick(); clear_inputs();
    w_init_done = 2'b01; tick(); w_init_done = 2'b10; tick(); w_init_done = 0;
    for (int s = 0; s < 255; s++) begin
      if (s == 254) begin
        check("sat_step254", 32'(step_cnt), 254);
        check("sat_mode254", 32'(op_mode), 32'(W_IN));
      end
      w_in_done = 1;  tick(); w_in_done = 0;
      calc_done = 1;  tick(); calc_done = 0;
      r_out_done = 1; tick(); r_out_done = 0;
    end
    check("sat_mode", 32'(op_mode), 32'(IDLE));
    check("sat_step", 32'(step_cnt), 255);
    check("sat_sd",   32'(seq_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
